// File: rtl/store_sched.sv
// Store reservation slots: capture operands from dispatch or result-bus snoop,
// then issue ready stores oldest-first over a single req/ack memory write port.
module store_sched #(
   parameter int NSLOT = 2,
   parameter int DW    = 32,
   parameter int TAGW  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc_valid,
   input  logic [1:0]           alloc_slot,
   input  logic                 alloc_rdy,
   input  logic [DW-1:0]        alloc_data,
   input  logic [TAGW-1:0]      alloc_qtag,
   input  logic [TAGW+DW-1:0]   addbus,
   input  logic [TAGW+DW-1:0]   multbus,
   input  logic [TAGW+DW-1:0]   loadbus,
   output logic                 mem_req,
   output logic [DW-1:0]        mem_data,
   input  logic                 mem_ack,
   output logic                 done_valid,
   output logic [TAGW-1:0]      done_tag,
   output logic [NSLOT-1:0]     slot_busy,
   output logic                 alloc_err
);
   // slot state | meaning
   // S_FREE     | unallocated
   // S_WAIT     | holding a producer tag, snooping the result buses
   // S_READY    | operand captured, eligible for arbitration
   // S_ISSUED   | owns the memory port until mem_ack
   typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} slot_st_e;

   slot_st_e          st_q    [NSLOT];
   slot_st_e          st_d    [NSLOT];
   logic [DW-1:0]     data_q  [NSLOT];
   logic [DW-1:0]     data_d  [NSLOT];
   logic [TAGW-1:0]   qtag_q  [NSLOT];
   logic [TAGW-1:0]   qtag_d  [NSLOT];
   logic [NSLOT-1:0]  older_q [NSLOT];   // older_q[i][j]: slot i is older than slot j
   logic [NSLOT-1:0]  older_d [NSLOT];
   logic              mem_req_q, mem_req_d;
   logic [DW-1:0]     mem_data_q, mem_data_d;
   logic              done_valid_q, done_valid_d;
   logic [TAGW-1:0]   done_tag_q, done_tag_d;
   logic              alloc_err_q, alloc_err_d;

   logic              ack, any_iss, found, cand, alloc_ok;
   logic [DW:0]       hit;
   logic [NSLOT-1:0]  busy;
   int                gnt, alloc_idx;

   // Tag 0 never matches; add beats mult beats load.
   function automatic logic [DW:0] snoop(input logic [TAGW-1:0] qt,
                                         input logic [TAGW+DW-1:0] ab,
                                         input logic [TAGW+DW-1:0] mb,
                                         input logic [TAGW+DW-1:0] lb);
      snoop = '0;
      if (qt != '0) begin
         if (ab[TAGW+DW-1:DW] == qt)      snoop = {1'b1, ab[DW-1:0]};
         else if (mb[TAGW+DW-1:DW] == qt) snoop = {1'b1, mb[DW-1:0]};
         else if (lb[TAGW+DW-1:DW] == qt) snoop = {1'b1, lb[DW-1:0]};
      end
   endfunction

   assign alloc_idx = int'(alloc_slot);
   assign ack       = mem_req_q & mem_ack;

   always_comb begin
      st_d         = st_q;
      data_d       = data_q;
      qtag_d       = qtag_q;
      older_d      = older_q;
      mem_req_d    = mem_req_q;
      mem_data_d   = mem_data_q;
      done_valid_d = 1'b0;
      done_tag_d   = '0;
      alloc_err_d  = 1'b0;
      any_iss      = 1'b0;
      alloc_ok     = 1'b0;
      found        = 1'b0;
      cand         = 1'b0;
      gnt          = 0;
      hit          = '0;
      busy         = '0;

      for (int i = 0; i < NSLOT; i++) begin
         busy[i] = (st_q[i] != S_FREE);
         if (st_q[i] == S_ISSUED) any_iss = 1'b1;
      end

      for (int i = 0; i < NSLOT; i++) begin
         if (st_q[i] == S_WAIT) begin
            hit = snoop(qtag_q[i], addbus, multbus, loadbus);
            if (hit[DW]) begin
               data_d[i] = hit[DW-1:0];
               st_d[i]   = S_READY;
            end
         end
         if (alloc_valid && alloc_idx == i && st_q[i] == S_FREE) begin
            alloc_ok   = 1'b1;
            older_d[i] = '0;
            for (int j = 0; j < NSLOT; j++)
               if (busy[j]) older_d[j][i] = 1'b1;
            if (alloc_rdy) begin
               data_d[i] = alloc_data;
               st_d[i]   = S_READY;
            end else begin
               hit       = snoop(alloc_qtag, addbus, multbus, loadbus);
               qtag_d[i] = alloc_qtag;
               if (hit[DW]) begin
                  data_d[i] = hit[DW-1:0];
                  st_d[i]   = S_READY;
               end else begin
                  st_d[i]   = S_WAIT;
               end
            end
         end
      end
      if (alloc_valid && !alloc_ok) alloc_err_d = 1'b1;

      // The acked slot frees after the allocation check, so it still rejects this cycle.
      for (int i = 0; i < NSLOT; i++) begin
         if (st_q[i] == S_ISSUED && ack) begin
            st_d[i]      = S_FREE;
            mem_req_d    = 1'b0;
            done_valid_d = 1'b1;
            done_tag_d   = TAGW'(32'h50 + i);
            older_d[i]   = '0;
            for (int j = 0; j < NSLOT; j++) older_d[j][i] = 1'b0;
         end
      end

      for (int i = 0; i < NSLOT; i++) begin
         if (!found && st_q[i] == S_READY) begin
            cand = 1'b1;
            for (int j = 0; j < NSLOT; j++)
               if (j != i && st_q[j] == S_READY && older_q[j][i]) cand = 1'b0;
            if (cand) begin
               found = 1'b1;
               gnt   = i;
            end
         end
      end
      if (!any_iss && found) begin
         st_d[gnt]  = S_ISSUED;
         mem_req_d  = 1'b1;
         mem_data_d = data_q[gnt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOT; i++) begin
            st_q[i]    <= S_FREE;
            data_q[i]  <= '0;
            qtag_q[i]  <= '0;
            older_q[i] <= '0;
         end
         mem_req_q    <= 1'b0;
         mem_data_q   <= '0;
         done_valid_q <= 1'b0;
         done_tag_q   <= '0;
         alloc_err_q  <= 1'b0;
      end else begin
         st_q         <= st_d;
         data_q       <= data_d;
         qtag_q       <= qtag_d;
         older_q      <= older_d;
         mem_req_q    <= mem_req_d;
         mem_data_q   <= mem_data_d;
         done_valid_q <= done_valid_d;
         done_tag_q   <= done_tag_d;
         alloc_err_q  <= alloc_err_d;
      end
   end

   always_comb begin
      slot_busy = '0;
      for (int i = 0; i < NSLOT; i++) slot_busy[i] = (st_q[i] != S_FREE);
   end

   assign mem_req    = mem_req_q;
   assign mem_data   = mem_data_q;
   assign done_valid = done_valid_q;
   assign done_tag   = done_tag_q;
   assign alloc_err  = alloc_err_q;
endmodule

// File: tb/tb_store_sched.sv
// Directed vector bench for store_sched: per-cycle input/expected-output table
// plus a hand-written reset-during-handshake sequence.
module tb_store_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc_valid, alloc_rdy, mem_ack;
   logic [1:0]  alloc_slot;
   logic [31:0] alloc_data;
   logic [7:0]  alloc_qtag;
   logic [39:0] addbus, multbus, loadbus;
   logic        mem_req, done_valid, alloc_err;
   logic [31:0] mem_data;
   logic [7:0]  done_tag;
   logic [1:0]  slot_busy;

   int nchk = 0;
   int nerr = 0;

   store_sched #(.NSLOT(2), .DW(32), .TAGW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_slot(alloc_slot), .alloc_rdy(alloc_rdy),
      .alloc_data(alloc_data), .alloc_qtag(alloc_qtag),
      .addbus(addbus), .multbus(multbus), .loadbus(loadbus),
      .mem_req(mem_req), .mem_data(mem_data), .mem_ack(mem_ack),
      .done_valid(done_valid), .done_tag(done_tag),
      .slot_busy(slot_busy), .alloc_err(alloc_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [1:0]  sl;
      logic        rdy;
      logic [31:0] d;
      logic [7:0]  qt;
      logic [39:0] ab, mb, lb;
      logic        ack;
      logic        e_req;
      logic [31:0] e_data;
      logic        e_dv;
      logic [7:0]  e_tag;
      logic [1:0]  e_busy;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid = 0; alloc_slot = 0; alloc_rdy = 0; alloc_data = 0; alloc_qtag = 0;
      addbus = 0; multbus = 0; loadbus = 0; mem_ack = 0;
   endtask

   initial begin
      // av sl rdy data qtag addbus multbus loadbus ack | req data dv tag busy err
      // direct store, ack held high (ack while req=0 is ignored)
      vq.push_back('{1,0,1,32'hDEADBEEF,0,0,0,0,1, 0,32'h0,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            1,32'hDEADBEEF,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'hDEADBEEF,1,8'h50,2'b00,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'hDEADBEEF,0,0,2'b00,0});
      // tag wakeup on addbus (add beats load)
      vq.push_back('{1,1,0,0,8'h21,0,0,0,0,        0,32'hDEADBEEF,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,{8'h22,32'hFF},0,0, 0,32'hDEADBEEF,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'hDEADBEEF,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,{8'h21,32'h7},0,{8'h21,32'h99},0, 0,32'hDEADBEEF,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h7,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'h7,1,8'h51,2'b00,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'h7,0,0,2'b00,0});
      // same-cycle capture, mult beats load
      vq.push_back('{1,0,0,0,8'h30,0,{8'h30,32'h5},{8'h30,32'h9},0, 0,32'h7,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h5,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'h5,1,8'h50,2'b00,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'h5,0,0,2'b00,0});
      // slot1 then slot0, delayed ack, data stable, bubble between requests
      vq.push_back('{1,1,1,32'hAAAA0001,0,0,0,0,0, 0,32'h5,0,0,2'b10,0});
      vq.push_back('{1,0,1,32'hBBBB0002,0,0,0,0,0, 1,32'hAAAA0001,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'hAAAA0001,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'hAAAA0001,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'hAAAA0001,1,8'h51,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'hBBBB0002,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'hBBBB0002,1,8'h50,2'b00,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'hBBBB0002,0,0,2'b00,0});
      // both wake the same cycle: older slot1 must win over lower index
      vq.push_back('{1,1,0,0,8'h41,0,0,0,0,        0,32'hBBBB0002,0,0,2'b10,0});
      vq.push_back('{1,0,0,0,8'h42,0,0,0,0,        0,32'hBBBB0002,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,{8'h42,32'h22},{8'h41,32'h11},0,0, 0,32'hBBBB0002,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h11,0,0,2'b11,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'h11,1,8'h51,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h22,0,0,2'b01,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'h22,1,8'h50,2'b00,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'h22,0,0,2'b00,0});
      // rejections: busy slot, out-of-range slot, slot freed by same-cycle ack
      vq.push_back('{1,0,1,32'h12345678,0,0,0,0,0, 0,32'h22,0,0,2'b01,0});
      vq.push_back('{1,0,1,32'hFFFFFFFF,0,0,0,0,0, 1,32'h12345678,0,0,2'b01,1});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h12345678,0,0,2'b01,0});
      vq.push_back('{1,3,1,32'h0,0,0,0,0,0,        1,32'h12345678,0,0,2'b01,1});
      vq.push_back('{1,0,1,32'hEEEEEEEE,0,0,0,0,1, 0,32'h12345678,1,8'h50,2'b00,1});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            0,32'h12345678,0,0,2'b00,0});
      vq.push_back('{1,1,1,32'h5555AAAA,0,0,0,0,0, 0,32'h12345678,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,0,0,0,            1,32'h5555AAAA,0,0,2'b10,0});
      vq.push_back('{0,0,0,0,0,0,0,0,1,            0,32'h5555AAAA,1,8'h51,2'b00,0});

      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      chk("reset mem_req", 64'(mem_req), 64'd0);
      chk("reset mem_data", 64'(mem_data), 64'd0);
      chk("reset done_valid", 64'(done_valid), 64'd0);
      chk("reset done_tag", 64'(done_tag), 64'd0);
      chk("reset slot_busy", 64'(slot_busy), 64'd0);
      chk("reset alloc_err", 64'(alloc_err), 64'd0);
      rst_n = 1;

      for (int k = 0; k < vq.size(); k++) begin
         alloc_valid = vq[k].av;  alloc_slot = vq[k].sl;  alloc_rdy = vq[k].rdy;
         alloc_data  = vq[k].d;   alloc_qtag = vq[k].qt;
         addbus = vq[k].ab; multbus = vq[k].mb; loadbus = vq[k].lb;
         mem_ack = vq[k].ack;
         tick();
         chk($sformatf("row%0d mem_req", k),    64'(mem_req),    64'(vq[k].e_req));
         chk($sformatf("row%0d mem_data", k),   64'(mem_data),   64'(vq[k].e_data));
         chk($sformatf("row%0d done_valid", k), 64'(done_valid), 64'(vq[k].e_dv));
         chk($sformatf("row%0d done_tag", k),   64'(done_tag),   64'(vq[k].e_tag));
         chk($sformatf("row%0d slot_busy", k),  64'(slot_busy),  64'(vq[k].e_busy));
         chk($sformatf("row%0d alloc_err", k),  64'(alloc_err),  64'(vq[k].e_err));
      end

      // reset asserted while a request is outstanding
      idle_inputs();
      tick();
      alloc_valid = 1; alloc_slot = 0; alloc_rdy = 1; alloc_data = 32'hCAFEF00D;
      tick();
      idle_inputs();
      tick();
      chk("pre-reset mem_req", 64'(mem_req), 64'd1);
      chk("pre-reset mem_data", 64'(mem_data), 64'hCAFEF00D);
      mem_ack = 1;
      #2 rst_n = 0;
      #1;
      chk("async reset mem_req", 64'(mem_req), 64'd0);
      chk("async reset slot_busy", 64'(slot_busy), 64'd0);
      chk("async reset mem_data", 64'(mem_data), 64'd0);
      tick();
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("post-reset%0d done_valid", k), 64'(done_valid), 64'd0);
         chk($sformatf("post-reset%0d mem_req", k), 64'(mem_req), 64'd0);
         chk($sformatf("post-reset%0d slot_busy", k), 64'(slot_busy), 64'd0);
      end
      mem_ack = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
